// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: single-cycle logic/arith/shift ops, iterative MULT/MULTU/DIV/DIVU.
// Latency counted from the accepting edge inclusive: 1 for ops 0-11, div-by-zero and DIV MIN/-1;
// WIDTH/MUL_BPC+1 for mul; WIDTH+1 for div. Backpressure: result held until out_ready.
//
// Ports: clk, rstn (async active-low); request in_valid/in_ready with op, a, b, shamt;
// response out_valid/out_ready with lo, hi (HI/LO for mul/div, hi=0 otherwise), zero (lo==0).
module alu_mc #(
    parameter int WIDTH   = 32,
    parameter int MUL_BPC = 1,
    localparam int SW     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SW-1:0]    shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    MUL_STEPS = CW'(WIDTH / MUL_BPC);
    localparam logic [CW-1:0]    DIV_STEPS = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod;      // {partial high half, multiplier bits not yet consumed}
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   quo;       // dividend shifts out the top while quotient bits shift in
    logic [WIDTH-1:0]   rem;
    logic               neg_p;
    logic               neg_q;
    logic               neg_r;

    logic               accept;
    logic               sgn_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   alu_lo;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign zero     = (lo == '0);

    // MULT (12) and DIV (14) are the even codes of their pairs
    assign sgn_op = ~op[0];
    assign a_neg  = sgn_op & a[WIDTH-1];
    assign b_neg  = sgn_op & b[WIDTH-1];
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;

    always_comb begin
        alu_lo = a;
        case (op)
            4'd1:    alu_lo = a + b;
            4'd2:    alu_lo = a - b;
            4'd3:    alu_lo = a & b;
            4'd4:    alu_lo = a | b;
            4'd5:    alu_lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd6:    alu_lo = {{(WIDTH-1){1'b0}}, (a < b)};
            4'd7:    alu_lo = b << shamt;
            4'd8:    alu_lo = ~(a | b);
            4'd9:    alu_lo = b >> shamt;
            4'd10:   alu_lo = $signed(b) >>> shamt;
            4'd11:   alu_lo = a ^ b;
            default: alu_lo = a;
        endcase
    end

    // Radix-2^MUL_BPC shift-add step: add mcand*digit into the high half, shift right.
    logic [WIDTH+MUL_BPC-1:0] mul_sum;
    logic [2*WIDTH-1:0]       prod_nxt;
    logic [2*WIDTH-1:0]       mul_fin;
    assign mul_sum  = {{MUL_BPC{1'b0}}, prod[2*WIDTH-1:WIDTH]}
                    + ({{MUL_BPC{1'b0}}, mcand} * {{WIDTH{1'b0}}, prod[MUL_BPC-1:0]});
    assign prod_nxt = {mul_sum, prod[WIDTH-1:MUL_BPC]};
    assign mul_fin  = neg_p ? -prod_nxt : prod_nxt;

    // Restoring division step: a borrow out of the trial subtract means "does not fit".
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_sub;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_fin;
    logic [WIDTH-1:0] rem_fin;
    assign rem_sh  = {rem, quo[WIDTH-1]};
    assign rem_sub = rem_sh - {1'b0, divisor};
    assign quo_nxt = {quo[WIDTH-2:0], ~rem_sub[WIDTH]};
    assign rem_nxt = rem_sub[WIDTH] ? rem_sh[WIDTH-1:0] : rem_sub[WIDTH-1:0];
    assign quo_fin = neg_q ? -quo_nxt : quo_nxt;
    assign rem_fin = neg_r ? -rem_nxt : rem_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            lo        <= '0;
            hi        <= '0;
            prod      <= '0;
            mcand     <= '0;
            divisor   <= '0;
            quo       <= '0;
            rem       <= '0;
            neg_p     <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                    if (accept) begin
                        if (op <= 4'd11) begin
                            lo        <= alu_lo;
                            hi        <= '0;
                            out_valid <= 1'b1;
                        end else if (op[3:1] == 3'b110) begin
                            state <= MUL;
                            cnt   <= MUL_STEPS;
                            mcand <= a_mag;
                            prod  <= {{WIDTH{1'b0}}, b_mag};
                            neg_p <= a_neg ^ b_neg;
                        end else if (b == '0) begin
                            lo        <= '1;
                            hi        <= a;
                            out_valid <= 1'b1;
                        end else if (sgn_op && (a == MIN_VAL) && (b == '1)) begin
                            // quotient magnitude 2^(WIDTH-1) is unrepresentable as positive
                            lo        <= MIN_VAL;
                            hi        <= '0;
                            out_valid <= 1'b1;
                        end else begin
                            state   <= DIV;
                            cnt     <= DIV_STEPS;
                            divisor <= b_mag;
                            quo     <= a_mag;
                            rem     <= '0;
                            neg_q   <= a_neg ^ b_neg;
                            neg_r   <= a_neg;
                        end
                    end
                end
                MUL: begin
                    prod <= prod_nxt;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        {hi, lo}  <= mul_fin;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                DIV: begin
                    quo <= quo_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        lo        <= quo_fin;
                        hi        <= rem_fin;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
`timescale 1ns/1ps
// Bench for alu_mc: reference model computes results with 64-bit arithmetic and the
// accept-to-valid latency; one negedge monitor compares every meaningful cycle.
// Directed cases plus randomized ops with random response backpressure.
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;

    alu_mc #(.WIDTH(32), .MUL_BPC(1)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready),
        .lo(lo), .hi(hi), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_pop = 0;
    bit   acc_flag = 1'b0;
    bit   rdy_rand = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: result from plain arithmetic; lat = edges from accept (inclusive) to out_valid.
    function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                  input logic [4:0] s, output logic [31:0] rlo,
                                  output logic [31:0] rhi, output int lat);
        logic signed [63:0] sx, sy, sq, sr;
        logic [63:0]        p;
        sx  = 64'($signed(x));
        sy  = 64'($signed(y));
        rhi = 32'h0;
        lat = 1;
        case (o)
            4'd0:  rlo = x;
            4'd1:  rlo = x + y;
            4'd2:  rlo = x - y;
            4'd3:  rlo = x & y;
            4'd4:  rlo = x | y;
            4'd5:  rlo = (sx < sy) ? 32'd1 : 32'd0;
            4'd6:  rlo = (x < y) ? 32'd1 : 32'd0;
            4'd7:  rlo = y << s;
            4'd8:  rlo = ~(x | y);
            4'd9:  rlo = y >> s;
            4'd10: rlo = 32'(sy >>> s);
            4'd11: rlo = x ^ y;
            4'd12: begin p = sx * sy; {rhi, rlo} = p; lat = 33; end
            4'd13: begin p = {32'h0, x} * {32'h0, y}; {rhi, rlo} = p; lat = 33; end
            4'd14: begin
                if (y == 0) begin rlo = 32'hFFFFFFFF; rhi = x; end
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin rlo = x; rhi = 0; end
                else begin
                    sq = sx / sy; sr = sx % sy;
                    rlo = sq[31:0]; rhi = sr[31:0]; lat = 33;
                end
            end
            default: begin
                if (y == 0) begin rlo = 32'hFFFFFFFF; rhi = x; end
                else begin rlo = x / y; rhi = x % y; lat = 33; end
            end
        endcase
    endfunction

    // Monitor: model-driven out_valid/in_ready, result contents, and acceptance.
    always @(negedge clk) begin
        bit   exp_ov, exp_ir;
        exp_t e;
        int   lat;
        acc_flag = 1'b0;
        if (!rstn) begin
            q.delete();
        end else begin
            exp_ov = (q.size() > 0) && (q[0].due <= cyc);
            exp_ir = (q.size() == 0) || (exp_ov && out_ready);
            chk("out_valid", 64'(out_valid), 64'(exp_ov));
            chk("in_ready", 64'(in_ready), 64'(exp_ir));
            if (exp_ov) begin
                chk("lo", 64'(lo), 64'(q[0].lo));
                chk("hi", 64'(hi), 64'(q[0].hi));
                chk("zero", 64'(zero), 64'(q[0].lo == 0));
                if (out_ready) begin
                    void'(q.pop_front());
                    n_pop++;
                end
            end
            if (in_valid && exp_ir) begin
                model(op, a, b, shamt, e.lo, e.hi, lat);
                e.due = cyc + lat;
                q.push_back(e);
                acc_flag = 1'b1;
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rdy_rand) out_ready = ($urandom_range(0, 9) < 7);
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] s);
        int budget;
        op = o; a = x; b = y; shamt = s; in_valid = 1'b1;
        budget = 300;
        do begin
            @(posedge clk);
            budget--;
        end while (!acc_flag && budget > 0);
        if (!acc_flag) chk("accept_timeout", 64'(0), 64'(1));
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 400;
        while (q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (q.size() > 0) chk("drain_timeout", 64'(q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [31:0] mlo, mhi;
        int          mlat, c0, p0, gap;

        // Hand-computed pins on the model itself
        model(4'd1, 32'h7FFFFFFF, 32'h1, 5'd0, mlo, mhi, mlat);
        chk("m_add", {mhi, mlo}, 64'h00000000_80000000);
        chk("m_add_lat", 64'(mlat), 64'd1);
        model(4'd10, 32'h0, 32'hF0000000, 5'd4, mlo, mhi, mlat);
        chk("m_sra", 64'(mlo), 64'hFF000000);
        model(4'd9, 32'h0, 32'hF0000000, 5'd4, mlo, mhi, mlat);
        chk("m_srl", 64'(mlo), 64'h0F000000);
        model(4'd5, 32'hFFFFFFFF, 32'h1, 5'd0, mlo, mhi, mlat);
        chk("m_slt", 64'(mlo), 64'd1);
        model(4'd6, 32'hFFFFFFFF, 32'h1, 5'd0, mlo, mhi, mlat);
        chk("m_sltu", 64'(mlo), 64'd0);
        model(4'd12, 32'hFFFFFFFD, 32'h5, 5'd0, mlo, mhi, mlat);
        chk("m_mult", {mhi, mlo}, 64'hFFFFFFFF_FFFFFFF1);
        chk("m_mult_lat", 64'(mlat), 64'd33);
        model(4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, mlo, mhi, mlat);
        chk("m_multu", {mhi, mlo}, 64'hFFFFFFFE_00000001);
        model(4'd14, 32'hFFFFFFF9, 32'h2, 5'd0, mlo, mhi, mlat);
        chk("m_div", {mhi, mlo}, 64'hFFFFFFFF_FFFFFFFD);
        model(4'd15, 32'h7, 32'h0, 5'd0, mlo, mhi, mlat);
        chk("m_divu0", {mhi, mlo}, 64'h00000007_FFFFFFFF);
        chk("m_divu0_lat", 64'(mlat), 64'd1);
        model(4'd14, 32'h80000000, 32'hFFFFFFFF, 5'd0, mlo, mhi, mlat);
        chk("m_divovf", {mhi, mlo}, 64'h00000000_80000000);

        // Reset state
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 4'd0; a = 32'h0; b = 32'h0; shamt = 5'd0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_lo_hi", {hi, lo}, 64'd0);
        chk("rst_zero", 64'(zero), 64'd1);
        @(posedge clk); #1;
        rstn = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed: T1-T4
        issue(4'd1,  32'h7FFFFFFF, 32'h00000001, 5'd0);
        issue(4'd10, 32'h0,        32'hF0000000, 5'd4);
        issue(4'd9,  32'h0,        32'hF0000000, 5'd4);
        issue(4'd5,  32'hFFFFFFFF, 32'h00000001, 5'd0);
        issue(4'd6,  32'hFFFFFFFF, 32'h00000001, 5'd0);
        issue(4'd12, 32'hFFFFFFFD, 32'h00000005, 5'd0);
        issue(4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
        issue(4'd14, 32'hFFFFFFF9, 32'h00000002, 5'd0);
        issue(4'd15, 32'h00000007, 32'h00000000, 5'd0);
        issue(4'd14, 32'h80000000, 32'hFFFFFFFF, 5'd0);
        issue(4'd2,  32'h5,        32'h5,        5'd0);
        drain();

        // T5: hold a result under backpressure, then back-to-back ADDs
        out_ready = 1'b0;
        issue(4'd1, 32'h12345678, 32'h11111111, 5'd0);
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
        p0 = n_pop;
        c0 = cyc;
        for (int i = 0; i < 8; i++) issue(4'd1, 32'(i * 3), 32'(100 + i), 5'd0);
        chk("b2b_cycles", 64'(cyc - c0), 64'd8);
        drain();
        chk("b2b_count", 64'(n_pop - p0), 64'd9);

        // Randomized ops with random response backpressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            issue(4'($urandom_range(0, 15)), pick(), pick(), 5'($urandom_range(0, 31)));
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
        end
        rdy_rand = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain();

        // T6: reset in the middle of a DIV
        issue(4'd15, 32'd100, 32'd7, 5'd0);
        repeat (10) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_lo_hi", {hi, lo}, 64'd0);
        chk("abort_zero", 64'(zero), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        issue(4'd1, 32'd2, 32'd3, 5'd0);
        #3;
        chk("after_abort_add", 64'(lo), 64'd5);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
